// File: rtl/display_arbiter_pkg.sv
// Shared watch definitions for the display arbiter.
//   state_e    : arbiter FSM states (show requester, mode banner, countdown alert)
//   MODE_*     : application codes carried on the 2-bit mode bus
//   PAIR_W     : bits per HEX digit pair; display values are {pair2, pair1, pair0}
package display_arbiter_pkg;

    localparam int unsigned PAIR_W = 7;
    localparam int unsigned NUM_W  = 3 * PAIR_W;

    localparam logic [1:0] MODE_CLOCK = 2'd0;
    localparam logic [1:0] MODE_STW   = 2'd1;
    localparam logic [1:0] MODE_CDT   = 2'd2;
    localparam logic [1:0] MODE_GAME  = 2'd3;

    typedef enum logic [1:0] {
        StShow,
        StBanner,
        StAlert
    } state_e;

endpackage

// File: rtl/dwell_timer.sv
// Saturating dwell timer: counts cycles spent in a state.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : clear the count (state entry); wins over en
//   en           : the owning state is currently active
//   done         : high on the LIMIT-th active cycle since the last start
module dwell_timer #(
    parameter int unsigned LIMIT = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic en,
    output logic done
);

    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count_q;

    // Holds at LAST rather than wrapping, so a stalled owner keeps seeing done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (start) begin
            count_q <= '0;
        end else if (en && (count_q != LAST)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign done = en && (count_q == LAST);

endmodule

// File: rtl/display_arbiter.sv
// Display arbiter: chooses which watch application drives the HEX display.
//   clk, reset_n                          : clock, asynchronous active-low reset
//   mode                                  : selected application
//   clk_num, stw_num, cdt_num, game_num   : requester values {num2, num1, num0}
//   clk_flash                             : clock edit-flash (bit1 -> pair 2, bit0 -> pair 1)
//   timeup                                : countdown-expired level
//   ack                                   : key pulse dismissing an alert
//   disp_num, disp_blank, src             : registered display value, pair blanks, granted source
//   banner_active, alert_active           : registered state flags
module display_arbiter
    import display_arbiter_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned BANNER_MS = 1000,
    parameter int unsigned ALERT_S   = 10,
    parameter int unsigned FLASH_HZ  = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       mode,
    input  logic [NUM_W-1:0] clk_num,
    input  logic [NUM_W-1:0] stw_num,
    input  logic [NUM_W-1:0] cdt_num,
    input  logic [NUM_W-1:0] game_num,
    input  logic [1:0]       clk_flash,
    input  logic             timeup,
    input  logic             ack,
    output logic [NUM_W-1:0] disp_num,
    output logic [2:0]       disp_blank,
    output logic [1:0]       src,
    output logic             banner_active,
    output logic             alert_active
);

    localparam int unsigned BANNER_CYC = BANNER_MS * CLK_HZ / 1000;
    localparam int unsigned ALERT_CYC  = ALERT_S * CLK_HZ;
    localparam int unsigned HALF_CYC   = CLK_HZ / (2 * FLASH_HZ);
    localparam int unsigned PW         = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(HALF_CYC - 1);

    state_e           state_q, state_d;
    logic [1:0]       mode_q;
    logic             timeup_q;
    logic             phase_q, phase_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic             mode_chg, tu_rise;
    logic             banner_start, alert_start, banner_done, alert_done;
    logic [NUM_W-1:0] num_d;
    logic [2:0]       blank_d;
    logic [1:0]       src_d;

    assign mode_chg = (mode != mode_q);
    assign tu_rise  = timeup && !timeup_q;

    always_comb begin
        state_d = state_q;
        if (tu_rise) begin
            // A fresh expiry outranks everything, including a same-cycle ack.
            state_d = StAlert;
        end else begin
            unique case (state_q)
                StShow:   if (mode_chg) state_d = StBanner;
                StBanner: if (!mode_chg && banner_done) state_d = StShow;
                StAlert:  if (ack || alert_done) state_d = StShow;
                default:  state_d = StShow;
            endcase
        end
    end

    // Entry into BANNER from elsewhere, or a restart on a further mode change.
    assign banner_start = (state_d == StBanner) && ((state_q != StBanner) || mode_chg);
    assign alert_start  = tu_rise;

    dwell_timer #(
        .LIMIT (BANNER_CYC)
    ) u_banner_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (banner_start),
        .en      (state_q == StBanner),
        .done    (banner_done)
    );

    dwell_timer #(
        .LIMIT (ALERT_CYC)
    ) u_alert_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (alert_start),
        .en      (state_q == StAlert),
        .done    (alert_done)
    );

    // Flash divider: phase starts dark-off (0) on every alert entry.
    always_comb begin
        phase_d = phase_q;
        pcnt_d  = pcnt_q;
        if (alert_start) begin
            phase_d = 1'b0;
            pcnt_d  = '0;
        end else if (state_q == StAlert) begin
            if (pcnt_q == PHASE_LAST) begin
                pcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end
    end

    // Outputs are computed from the next state so they appear one cycle after the inputs.
    always_comb begin
        num_d   = '0;
        blank_d = 3'b000;
        src_d   = mode;
        unique case (state_d)
            StBanner: begin
                num_d   = {PAIR_W'(mode) + PAIR_W'(1), {(2 * PAIR_W){1'b0}}};
                blank_d = 3'b011;
            end
            StAlert: begin
                num_d   = cdt_num;
                blank_d = {3{phase_d}};
                src_d   = MODE_CDT;
            end
            default: begin
                unique case (mode)
                    MODE_CLOCK: num_d = clk_num;
                    MODE_STW:   num_d = stw_num;
                    MODE_CDT:   num_d = cdt_num;
                    default:    num_d = game_num;
                endcase
                blank_d = (mode == MODE_CLOCK) ? {clk_flash, 1'b0} : 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StShow;
            mode_q        <= 2'd0;
            timeup_q      <= 1'b0;
            phase_q       <= 1'b0;
            pcnt_q        <= '0;
            disp_num      <= '0;
            disp_blank    <= 3'b000;
            src           <= 2'd0;
            banner_active <= 1'b0;
            alert_active  <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode;
            timeup_q      <= timeup;
            phase_q       <= phase_d;
            pcnt_q        <= pcnt_d;
            disp_num      <= num_d;
            disp_blank    <= blank_d;
            src           <= src_d;
            banner_active <= (state_d == StBanner);
            alert_active  <= (state_d == StAlert);
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
`timescale 1ns/1ps
module tb_display_arbiter;

    localparam int unsigned CLK_HZ     = 1000;
    localparam int unsigned BANNER_MS  = 10;
    localparam int unsigned ALERT_S    = 1;
    localparam int unsigned FLASH_HZ   = 50;
    localparam int          BANNER_CYC = 10;
    localparam int          ALERT_CYC  = 1000;
    localparam int          HALF_CYC   = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [20:0] clk_num = '0, stw_num = '0, cdt_num = '0, game_num = '0;
    logic [1:0]  clk_flash = 2'b00;
    logic        timeup = 1'b0;
    logic        ack = 1'b0;
    logic [20:0] disp_num;
    logic [2:0]  disp_blank;
    logic [1:0]  src;
    logic        banner_active, alert_active;

    always #5 clk = ~clk;

    display_arbiter #(
        .CLK_HZ    (CLK_HZ),
        .BANNER_MS (BANNER_MS),
        .ALERT_S   (ALERT_S),
        .FLASH_HZ  (FLASH_HZ)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mode          (mode),
        .clk_num       (clk_num),
        .stw_num       (stw_num),
        .cdt_num       (cdt_num),
        .game_num      (game_num),
        .clk_flash     (clk_flash),
        .timeup        (timeup),
        .ack           (ack),
        .disp_num      (disp_num),
        .disp_blank    (disp_blank),
        .src           (src),
        .banner_active (banner_active),
        .alert_active  (alert_active)
    );

    typedef struct packed {
        logic [20:0] num;
        logic [2:0]  blank;
        logic [1:0]  src;
        logic        ba;
        logic        aa;
    } out_t;

    out_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   rand_data = 1'b1;

    // Reference model: which screen is up and how many cycles it has been shown.
    int         m_state = 0;  // 0 = requester, 1 = banner, 2 = alert
    int         m_shown = 0;
    logic [1:0] m_mode_prev = 2'd0;
    logic       m_tu_prev = 1'b0;

    task automatic model_reset();
        m_state = 0;
        m_shown = 0;
        m_mode_prev = 2'd0;
        m_tu_prev = 1'b0;
    endtask

    // Apply current inputs for one cycle, queue the response expected after the next edge.
    task automatic step();
        bit   rise, chg, enter;
        int   nxt, idx, v;
        out_t e;
        if (rand_data) begin
            clk_num  = 21'($urandom);
            stw_num  = 21'($urandom);
            cdt_num  = 21'($urandom);
            game_num = 21'($urandom);
        end
        rise  = timeup && !m_tu_prev;
        chg   = (mode != m_mode_prev);
        m_shown++;
        nxt   = m_state;
        enter = 1'b0;
        if (rise) begin
            nxt = 2;
            enter = 1'b1;
        end else begin
            case (m_state)
                0: if (chg) begin nxt = 1; enter = 1'b1; end
                1: begin
                    if (chg) enter = 1'b1;
                    else if (m_shown >= BANNER_CYC) begin nxt = 0; enter = 1'b1; end
                end
                default: if (ack || m_shown >= ALERT_CYC) begin nxt = 0; enter = 1'b1; end
            endcase
        end
        if (enter) m_shown = 0;
        m_state = nxt;
        m_mode_prev = mode;
        m_tu_prev = timeup;
        idx = m_shown;
        e = '0;
        case (m_state)
            0: begin
                case (mode)
                    2'd0: e.num = clk_num;
                    2'd1: e.num = stw_num;
                    2'd2: e.num = cdt_num;
                    default: e.num = game_num;
                endcase
                e.blank = (mode == 2'd0) ? 3'(int'(clk_flash) * 2) : 3'd0;
                e.src = mode;
            end
            1: begin
                v = int'(mode) + 1;
                e.num = 21'(v << 14);
                e.blank = 3'b011;
                e.src = mode;
                e.ba = 1'b1;
            end
            default: begin
                e.num = cdt_num;
                e.blank = (((idx / HALF_CYC) % 2) == 1) ? 3'b111 : 3'b000;
                e.src = 2'd2;
                e.aa = 1'b1;
            end
        endcase
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_zero(input string name);
        out_t a;
        a = {disp_num, disp_blank, src, banner_active, alert_active};
        checks++;
        if (a !== '0) begin
            failures++;
            $display("FAIL %s got=%h required=0", name, a);
        end
    endtask

    // Monitor: one output word per clock while out of reset.
    initial begin
        out_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL no_expectation t=%0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    a = {disp_num, disp_blank, src, banner_active, alert_active};
                    if (a !== e) begin
                        failures++;
                        $display("FAIL cycle_out t=%0t got num=%h blank=%b src=%0d ba=%b aa=%b required num=%h blank=%b src=%0d ba=%b aa=%b",
                                 $time, a.num, a.blank, a.src, a.ba, a.aa,
                                 e.num, e.blank, e.src, e.ba, e.aa);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1 check_zero("reset_init");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        steps(5);

        // Mode change banner, then the stopwatch value.
        rand_data = 1'b0;
        stw_num = 21'h01020;
        mode = 2'd1;
        steps(15);
        rand_data = 1'b1;

        // Clock edit flash patterns.
        mode = 2'd0;
        steps(12);
        clk_flash = 2'b10; steps(2);
        clk_flash = 2'b01; steps(2);
        clk_flash = 2'b11; steps(2);
        mode = 2'd1;
        steps(12);
        clk_flash = 2'b10; steps(2);
        clk_flash = 2'b00;

        // Alert timeout with timeup held high past the end.
        mode = 2'd0;
        steps(12);
        timeup = 1'b1;
        steps(1005);
        timeup = 1'b0;
        steps(2);

        // Ack dismiss partway into an alert.
        timeup = 1'b1;
        steps(37);
        ack = 1'b1; step(); ack = 1'b0;
        steps(5);
        timeup = 1'b0;
        step();

        // Ack outside alert is ignored.
        ack = 1'b1; step(); ack = 1'b0;
        steps(2);

        // Preemption of a banner, and a mode change recorded during alert.
        mode = 2'd2;
        steps(3);
        timeup = 1'b1;
        step();
        mode = 2'd3;
        steps(20);
        ack = 1'b1; step(); ack = 1'b0;
        steps(5);
        timeup = 1'b0;
        step();

        // Same-cycle ack and new timeup edge restarts the alert.
        timeup = 1'b1; steps(30);
        timeup = 1'b0; step();
        timeup = 1'b1; ack = 1'b1; step();
        ack = 1'b0;
        steps(25);
        timeup = 1'b0;
        ack = 1'b1; step(); ack = 1'b0;
        steps(3);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 29) == 0) timeup = ~timeup;
            ack = ($urandom_range(0, 24) == 0);
            clk_flash = 2'($urandom);
            step();
        end
        ack = 1'b0;
        timeup = 1'b0;
        step();

        // Asynchronous reset in the middle of an alert.
        timeup = 1'b1;
        steps(15);
        #2 reset_n = 1'b0;
        #1 check_zero("reset_mid_alert");
        mode = 2'd2;
        repeat (2) @(negedge clk);
        check_zero("reset_held");
        model_reset();
        reset_n = 1'b1;  // timeup already high: counts as a rising edge
        steps(10);
        timeup = 1'b0;
        ack = 1'b1; step(); ack = 1'b0;
        steps(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
